// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port arbiter slice:
// state encodings, requester IDs and default widths.
package bram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t ACCESS_W = 2'd1;
    localparam state_t ACCESS_R = 2'd2;
    localparam state_t RD_WAIT  = 2'd3;

    localparam int REQ_W = 0;
    localparam int REQ_R = 1;

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-way round-robin picker. The grant is combinational;
// the last-served flop lives here and advances on update.
module bram_arb_rr2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 1 = read served last, so first contention goes to write
    logic last_served;

    // remember who won the most recent grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_served <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            last_served <= gnt[REQ_R];
        end
    end

    // favour the requester that was not served last
    always_comb begin
        gnt        = 2'b00;
        gnt[REQ_W] = req[REQ_W] & (~req[REQ_R] | last_served);
        gnt[REQ_R] = req[REQ_R] & (~req[REQ_W] | ~last_served);
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between a writer and a reader.
// One access in flight; all outputs come straight from flops.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_gnt,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic              busy,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    state_t            state;
    state_t            next_state;
    logic [1:0]        pick;
    logic              w_gnt_d;
    logic              r_gnt_d;
    logic              r_valid_d;
    logic              busy_d;
    logic              en_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d;

    bram_arb_rr2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({r_req, w_req}),
        .update (state == IDLE),
        .gnt    (pick)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // requests are only looked at while idle; nothing is queued
    always_comb begin
        next_state = IDLE;
        unique case (state)
            IDLE: begin
                if (pick[REQ_W]) begin
                    next_state = ACCESS_W;
                end else if (pick[REQ_R]) begin
                    next_state = ACCESS_R;
                end
            end
            ACCESS_W: next_state = IDLE;
            ACCESS_R: next_state = RD_WAIT;
            RD_WAIT:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // decode next-cycle outputs from the upcoming state
    always_comb begin
        w_gnt_d   = (next_state == ACCESS_W);
        r_gnt_d   = (next_state == ACCESS_R);
        en_d      = w_gnt_d | r_gnt_d;
        we_d      = w_gnt_d;
        busy_d    = (next_state != IDLE);
        r_valid_d = (state == RD_WAIT);
        addr_d    = bram_addr;
        din_d     = bram_din;
        if (w_gnt_d) begin
            addr_d = w_addr;
            din_d  = w_data;
        end else if (r_gnt_d) begin
            addr_d = r_addr;
        end
    end

    // output registers; read data captured as RD_WAIT ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_gnt     <= 1'b0;
            r_gnt     <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            busy      <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            w_gnt     <= w_gnt_d;
            r_gnt     <= r_gnt_d;
            r_valid   <= r_valid_d;
            busy      <= busy_d;
            bram_en   <= en_d;
            bram_we   <= we_d;
            bram_addr <= addr_d;
            bram_din  <= din_d;
            if (state == RD_WAIT) begin
                r_data <= bram_dout;
            end
        end
    end

endmodule
